dma_line_buffer: RTL and testbench

Upstream fill stage for the CRC compute stage. Collects 32-bit read beats from the DMA memory read port into an eight-word line register, then presents the complete line with a valid/ack handshake. The consumer samples the line while the DMA controller is in its compute state. Words are stored in arrival order; unused words are zero-filled so the consumer always sees a deterministic 8x32 line.

---
 rtl/dma_line_buffer_if.sv | 31 +++
 rtl/dma_line_buffer.sv | 119 +++++++++++
 tb/tb_dma_line_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_line_buffer_if.sv
// Bus bundle for dma_line_buffer: DMA read-beat port, start/length control
// and the line valid/ack handshake toward the CRC consumer.
interface dma_line_buffer_if #(
   parameter int WORDS  = 8,
   parameter int DATA_W = 32
);
   localparam int CW = $clog2(WORDS) + 1;

   logic                          start_i;
   logic [CW-1:0]                 len_i;
   logic                          rd_valid_i;
   logic [DATA_W-1:0]             rd_data_i;
   logic                          rd_error_i;
   logic                          rd_ready_o;
   logic [WORDS-1:0][DATA_W-1:0]  data_reg_o;
   logic                          line_valid_o;
   logic                          line_ack_i;
   logic [CW-1:0]                 words_o;
   logic                          busy_o;
   logic                          error_o;

   modport slave (
      input  start_i, len_i, rd_valid_i, rd_data_i, rd_error_i, line_ack_i,
      output rd_ready_o, data_reg_o, line_valid_o, words_o, busy_o, error_o
   );

   modport master (
      output start_i, len_i, rd_valid_i, rd_data_i, rd_error_i, line_ack_i,
      input  rd_ready_o, data_reg_o, line_valid_o, words_o, busy_o, error_o
   );
endinterface

// File: rtl/dma_line_buffer.sv
// Collects DMA read beats into a WORDS x DATA_W line and hands it to the CRC stage.
// Optional macro DMA_LINE_BUF_BYTE_SWAP_EN byte-reverses each word before storage.
module dma_line_buffer #(
   parameter int WORDS  = 8,
   parameter int DATA_W = 32
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   dma_line_buffer_if.slave   bus,
   output logic [1:0]         state_o
);
   localparam int CW = $clog2(WORDS) + 1;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

   state_e                        state_q, state_d;
   logic [CW-1:0]                 len_q, len_d;
   logic [CW-1:0]                 words_q, words_d;
   logic [WORDS-1:0][DATA_W-1:0]  data_q, data_d;
   logic                          rd_ready_q, rd_ready_d;
   logic                          line_valid_q, line_valid_d;
   logic                          busy_q, busy_d;
   logic                          error_q, error_d;

   logic [CW-1:0]                 eff_len;
   logic [CW-1:0]                 words_inc;
   logic [DATA_W-1:0]             store_word;
   logic                          beat_fire;

`ifdef DMA_LINE_BUF_BYTE_SWAP_EN
   function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int b = 0; b < DATA_W / 8; b++) begin
         r[8*b +: 8] = w[DATA_W-8-8*b +: 8];
      end
      return r;
   endfunction

   assign store_word = byte_swap(bus.rd_data_i);
`else
   assign store_word = bus.rd_data_i;
`endif

   // Handshake: a beat transfers on a rising edge where rd_valid_i && rd_ready_o;
   // the line transfers on the edge where line_valid_o && line_ack_i.
   assign beat_fire = bus.rd_valid_i && rd_ready_q;
   assign eff_len   = ((bus.len_i == '0) || (bus.len_i > CW'(WORDS))) ? CW'(WORDS) : bus.len_i;
   assign words_inc = words_q + CW'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      words_d = words_q;
      data_d  = data_q;
      error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = FILL;
               len_d   = eff_len;
               words_d = '0;
               data_d  = '0;
            end
         end
         FILL: begin
            if (beat_fire) begin
               // An errored beat aborts the fill without touching the line.
               if (bus.rd_error_i) begin
                  state_d = IDLE;
                  error_d = 1'b1;
               end else begin
                  data_d[words_q[IW-1:0]] = store_word;
                  words_d = words_inc;
                  if (words_inc == len_q) state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.line_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rd_ready_d   = (state_d == FILL);
      line_valid_d = (state_d == HOLD);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         len_q        <= '0;
         words_q      <= '0;
         data_q       <= '0;
         rd_ready_q   <= 1'b0;
         line_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         words_q      <= words_d;
         data_q       <= data_d;
         rd_ready_q   <= rd_ready_d;
         line_valid_q <= line_valid_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign bus.rd_ready_o   = rd_ready_q;
   assign bus.line_valid_o = line_valid_q;
   assign bus.busy_o       = busy_q;
   assign bus.error_o      = error_q;
   assign bus.words_o      = words_q;
   assign bus.data_reg_o   = data_q;
   assign state_o          = state_q;
endmodule

// File: tb/tb_dma_line_buffer.sv
// Randomized bench for dma_line_buffer: transaction-level model of line fills
// (expected words queued per fill) compared against the line at hand-off.
module tb_dma_line_buffer;
   localparam int WORDS  = 8;
   localparam int DATA_W = 32;
   localparam int CW     = $clog2(WORDS) + 1;
   localparam int LW     = WORDS * DATA_W;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] exp_q[$];

   dma_line_buffer_if #(.WORDS(WORDS), .DATA_W(DATA_W)) bus ();

   dma_line_buffer #(.WORDS(WORDS), .DATA_W(DATA_W)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus),
      .state_o   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model helpers ----------------
   function automatic int eff_len(input int len);
      return (len == 0 || len > WORDS) ? WORDS : len;
   endfunction

   function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] b);
`ifdef DMA_LINE_BUF_BYTE_SWAP_EN
      return {b[7:0], b[15:8], b[23:16], b[31:24]};
`else
      return b;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] beat_value(input int mode, input int i);
      case (mode)
         1:       return 32'h1111_1111 * (i + 1);
         2:       return 32'hA + i;
         3:       return 32'h1234_5678;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, LW'(bus.rd_ready_o), '0);
      check({tag, "_valid"}, LW'(bus.line_valid_o), '0);
      check({tag, "_busy"}, LW'(bus.busy_o), '0);
      check({tag, "_error"}, LW'(bus.error_o), '0);
      check({tag, "_words"}, LW'(bus.words_o), '0);
      check({tag, "_data"}, LW'(bus.data_reg_o), '0);
   endtask

   // One complete fill. err_idx < 0 means no error beat; stop_after > 0 returns
   // right after that many beats (used for the mid-fill reset).
   task automatic run_fill(input int len, input int err_idx, input int max_gap,
                           input bit poke, input int mode, input int stop_after);
      int L;
      int gap;
      logic [DATA_W-1:0] beat;
      logic [DATA_W-1:0] w;
      logic [LW-1:0] line_v;

      L = eff_len(len);
      exp_q.delete();
      bus.start_i = 1'b1;
      bus.len_i   = CW'(len);
      step();
      bus.start_i = 1'b0;
      bus.len_i   = CW'($urandom);
      check("fill_busy", LW'(bus.busy_o), 1);
      check("fill_ready", LW'(bus.rd_ready_o), 1);
      check("fill_words0", LW'(bus.words_o), 0);
      check("fill_clear", LW'(bus.data_reg_o), '0);

      for (int i = 0; i < L; i++) begin
         gap = $urandom_range(0, max_gap);
         repeat (gap) step();
         if (poke && i == 1) begin
            bus.start_i    = 1'b1;
            bus.line_ack_i = 1'b1;
            step();
            bus.start_i    = 1'b0;
            bus.line_ack_i = 1'b0;
            check("poke_fill_words", LW'(bus.words_o), LW'(i));
            check("poke_fill_ready", LW'(bus.rd_ready_o), 1);
            check("poke_fill_valid", LW'(bus.line_valid_o), 0);
         end
         beat = beat_value(mode, i);
         bus.rd_valid_i = 1'b1;
         bus.rd_data_i  = beat;
         bus.rd_error_i = (i == err_idx);
         step();
         bus.rd_valid_i = 1'b0;
         bus.rd_error_i = 1'b0;
         bus.rd_data_i  = $urandom;
         if (i == err_idx) begin
            check("err_pulse", LW'(bus.error_o), 1);
            check("err_busy", LW'(bus.busy_o), 0);
            check("err_valid", LW'(bus.line_valid_o), 0);
            check("err_ready", LW'(bus.rd_ready_o), 0);
            step();
            check("err_pulse_end", LW'(bus.error_o), 0);
            check("err_valid_after", LW'(bus.line_valid_o), 0);
            exp_q.delete();
            return;
         end
         exp_q.push_back(exp_word(beat));
         if (stop_after > 0 && i + 1 == stop_after) return;
         if (i < L - 1) begin
            check("mid_valid", LW'(bus.line_valid_o), 0);
            check("mid_words", LW'(bus.words_o), LW'(i + 1));
         end
      end

      check("hold_valid", LW'(bus.line_valid_o), 1);
      check("hold_ready", LW'(bus.rd_ready_o), 0);
      check("hold_busy", LW'(bus.busy_o), 1);
      check("hold_words", LW'(bus.words_o), LW'(L));
      line_v = '0;
      for (int wi = 0; wi < WORDS; wi++) begin
         w = (wi < L) ? exp_q.pop_front() : '0;
         line_v[DATA_W*wi +: DATA_W] = w;
         check($sformatf("line_word%0d", wi), LW'(bus.data_reg_o[wi]), LW'(w));
      end

      // Beat past the line length must not be taken.
      bus.rd_valid_i = 1'b1;
      bus.rd_data_i  = $urandom;
      step();
      step();
      bus.rd_valid_i = 1'b0;
      check("extra_words", LW'(bus.words_o), LW'(L));
      check("extra_data", LW'(bus.data_reg_o), line_v);
      check("extra_error", LW'(bus.error_o), 0);

      if (poke) begin
         bus.start_i = 1'b1;
         step();
         bus.start_i = 1'b0;
         check("poke_hold_valid", LW'(bus.line_valid_o), 1);
         check("poke_hold_words", LW'(bus.words_o), LW'(L));
      end

      bus.line_ack_i = 1'b1;
      bus.start_i    = poke;
      step();
      bus.line_ack_i = 1'b0;
      bus.start_i    = 1'b0;
      check("ack_valid", LW'(bus.line_valid_o), 0);
      check("ack_busy", LW'(bus.busy_o), 0);
      check("ack_ready", LW'(bus.rd_ready_o), 0);
      check("ack_retain", LW'(bus.data_reg_o), line_v);
      step();
      check("idle_busy", LW'(bus.busy_o), 0);
      check("idle_retain", LW'(bus.data_reg_o), line_v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int len;
      int err;
      rst_n          = 1'b0;
      bus.start_i    = 1'b0;
      bus.len_i      = '0;
      bus.rd_valid_i = 1'b0;
      bus.rd_data_i  = '0;
      bus.rd_error_i = 1'b0;
      bus.line_ack_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      step();
      check_reset_values("post_reset");

      run_fill(8, -1, 0, 1'b0, 1, 0);
      run_fill(3, -1, 2, 1'b0, 2, 0);
      run_fill(0, -1, 1, 1'b1, 0, 0);
      run_fill(8, 1, 0, 1'b0, 0, 0);
      run_fill(8, -1, 0, 1'b0, 1, 0);

      run_fill(8, -1, 0, 1'b0, 0, 5);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      #2;
      rst_n = 1'b1;
      step();
      run_fill(8, -1, 0, 1'b0, 1, 0);

      run_fill(1, -1, 0, 1'b0, 3, 0);

      for (int t = 0; t < 24; t++) begin
         len = $urandom_range(0, (1 << CW) - 1);
         err = ($urandom_range(0, 3) == 0) ? $urandom_range(0, eff_len(len) - 1) : -1;
         run_fill(len, err, 3, 1'($urandom_range(0, 1)), 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
